// File: rtl/stop_watch_bcd_lap.sv
// N-digit BCD up/down stopwatch with prescaler, wrap/saturate range policy
// and a lap/split display freeze.

module stop_watch_bcd_digit (
    input  logic       i_dir,
    input  logic       i_lo9,
    input  logic       i_lo0,
    input  logic [3:0] i_d,
    output logic [3:0] o_nxt
);
    always_comb begin
        o_nxt = i_d;
        if (!i_dir) begin
            if (i_lo9) o_nxt = (i_d >= 4'd9) ? 4'd0 : i_d + 4'd1;
        end else if (i_lo0) begin
            o_nxt = (i_d == 4'd0 || i_d > 4'd9) ? 4'd9 : i_d - 4'd1;
        end
    end
endmodule

module stop_watch_bcd_lap #(
    parameter int DVSR = 5000000,
    parameter int NDIG = 3,
    parameter int WRAP = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_go,
    input  logic              i_clr,
    input  logic              i_dir,
    input  logic              i_lap,
    output logic [4*NDIG-1:0] o_digits,
    output logic              o_lap_active,
    output logic              o_ovf,
    output logic              o_tick
);
    localparam int PW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DVSR - 1);

    typedef enum logic {LIVE, FROZEN} state_t;

    logic [PW-1:0]             r_psc;
    logic [NDIG-1:0][3:0]      r_cnt;
    logic [NDIG-1:0][3:0]      r_snap;
    logic [NDIG-1:0][3:0]      w_cnt_nxt;
    logic [NDIG-1:0]           w_lo9;
    logic [NDIG-1:0]           w_lo0;
    logic                      r_ovf;
    logic                      w_tick;
    logic                      w_all9;
    logic                      w_all0;
    logic                      w_end;
    logic                      w_sclr;
    state_t                    r_state;
    state_t                    w_state_nxt;

    assign w_sclr = !i_rst_n || i_clr;
    // Gated so tick never pulses in a reset or clear cycle.
    assign w_tick = !w_sclr && i_go && (r_psc == PMAX);

    always_ff @(posedge i_clk) begin
        if (w_sclr)
            r_psc <= '0;
        else if (i_go)
            r_psc <= (r_psc == PMAX) ? '0 : r_psc + 1'b1;
    end

    // w_lo9[g]/w_lo0[g]: every digit below g is 9 / 0.
    always_comb begin
        w_all9 = 1'b1;
        w_all0 = 1'b1;
        w_lo9  = '0;
        w_lo0  = '0;
        for (int k = 0; k < NDIG; k++) begin
            w_lo9[k] = w_all9;
            w_lo0[k] = w_all0;
            if (r_cnt[k] != 4'd9) w_all9 = 1'b0;
            if (r_cnt[k] != 4'd0) w_all0 = 1'b0;
        end
    end

    assign w_end = i_dir ? w_all0 : w_all9;

    for (genvar g = 0; g < NDIG; g++) begin : g_dig
        stop_watch_bcd_digit u_dig (
            .i_dir (i_dir),
            .i_lo9 (w_lo9[g]),
            .i_lo0 (w_lo0[g]),
            .i_d   (r_cnt[g]),
            .o_nxt (w_cnt_nxt[g])
        );
    end

    always_ff @(posedge i_clk) begin
        if (w_sclr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_tick) begin
            if (w_end) r_ovf <= 1'b1;
            // Saturate mode simply refuses the move past the range end.
            if (WRAP != 0 || !w_end) r_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_lap) w_state_nxt = (r_state == LIVE) ? FROZEN : LIVE;
    end

    always_ff @(posedge i_clk) begin
        if (w_sclr) begin
            r_state <= LIVE;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == LIVE && i_lap) r_snap <= r_cnt;
        end
    end

    assign o_digits     = (r_state == FROZEN) ? r_snap : r_cnt;
    assign o_lap_active = (r_state == FROZEN);
    assign o_ovf        = r_ovf;
    assign o_tick       = w_tick;
endmodule
